ps2_kbd_ctrl: RTL and testbench
===============================

PS2_KBD_CTRL -- requirements
Module: ps2_kbd_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the key-press counter.
REQ-002 SHALL have parameter FILTER_REPEAT, default 1: 1 drops typematic repeat make codes of the currently held key.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port clrn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port kbd_data  input  8  scan byte from the keyboard receiver FIFO, valid in the cycle after a pop.
REQ-006 SHALL have port kbd_ready  input  1  receiver FIFO non-empty.
REQ-007 SHALL have port kbd_overflow  input  1  receiver FIFO overflow flag, sticky in the receiver.
REQ-008 SHALL have port kbd_nextdata_n  output  1  active-low pop strobe to the receiver FIFO.
REQ-009 SHALL have port evt_valid  output  1  key event available.
REQ-010 SHALL have port evt_ready  input  1  consumer accepts event.
REQ-011 SHALL have port evt_code  output  8  event scan code, prefixes stripped.
REQ-012 SHALL have port evt_ext  output  1  event was E0-prefixed.
REQ-013 SHALL have port evt_break  output  1  1 = release, 0 = press.
REQ-014 SHALL have port key_held  output  1  a key is currently held (per held-key register).
REQ-015 SHALL have port press_cnt  output  CNT_W  count of accepted make events.
REQ-016 SHALL have port err_ovf  output  1  sticky: overflow seen since reset.

Function
REQ-017 SHALL implement FSM states IDLE, POP, CAPT, EMIT.
REQ-018 SHALL: IDLE with kbd_ready=1 -> POP; else stay IDLE.
REQ-019 SHALL drive kbd_nextdata_n=0 in POP only, exactly one cycle, never in consecutive cycles; POP -> CAPT unconditionally.
REQ-020 SHALL sample kbd_data in CAPT (pop-then-read protocol) and decode it in that cycle.
REQ-021 SHALL decode byte 0xE0: set ext_pend; CAPT -> IDLE; no event.
REQ-022 SHALL decode byte 0xF0: set brk_pend; CAPT -> IDLE; no event.
REQ-023 SHALL treat bytes 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF as control: drop, clear both pend flags, CAPT -> IDLE.
REQ-024 SHALL treat any other byte as key code: latch evt_code=byte, evt_ext=ext_pend, evt_break=brk_pend, clear both pend flags.
REQ-025 SHALL, on a break key code matching held register {ext,code}, clear key_held; CAPT -> EMIT.
REQ-026 SHALL, on a make key code with FILTER_REPEAT=1, key_held=1 and {ext,code} equal to the held register: drop silently (no event, no count); CAPT -> IDLE.
REQ-027 SHALL, on any other make key code: load held register, set key_held, increment press_cnt modulo 2^CNT_W (wraps FF->00 for CNT_W=8); CAPT -> EMIT.
REQ-028 SHALL assert evt_valid only in EMIT; evt_code/ext/break stable while evt_valid=1; EMIT -> IDLE on the cycle evt_valid & evt_ready.
REQ-029 SHALL not pop the FIFO while in EMIT (backpressure holds bytes in the receiver).
REQ-030 SHALL give latency: kbd_ready rising in cycle n (state IDLE) -> pop in n+1 -> capture n+2 -> evt_valid from n+3; peak throughput one byte per 3 cycles.
REQ-031 SHALL, on kbd_overflow=1 while err_ovf=0, set err_ovf and clear ext_pend/brk_pend in the same cycle; err_ovf cleared only by reset.
REQ-032 SHALL apply prefix flags cumulatively: E0 F0 <code> yields ext=1, break=1; repeated prefixes are idempotent.
REQ-033 SHALL make kbd_ready falling during POP or CAPT have no effect; the captured byte is still decoded.

Reset
REQ-034 SHALL, on clrn=0 at any time including mid-handshake, asynchronously enter IDLE and set kbd_nextdata_n=1, evt_valid=0, evt_code=0x00, evt_ext=0, evt_break=0, key_held=0, press_cnt=0, err_ovf=0, pend flags=0, held register=0.
REQ-035 SHALL resume normal operation on the first clk edge after clrn deasserts, with no pop issued in that cycle.

Verification
REQ-036 SHALL verify: FIFO delivers 0x1C, evt_ready=1 -> one pop, event code=0x1C ext=0 break=0, press_cnt=1, key_held=1; then F0 1C -> event break=1, key_held=0.
REQ-037 SHALL verify: E0 F0 75 -> single event code=0x75 ext=1 break=1, two dropped prefix bytes, exactly three pops.
REQ-038 SHALL verify: 1C 1C 1C with FILTER_REPEAT=1 -> one event, press_cnt=1; with FILTER_REPEAT=0 -> three events, press_cnt=3.
REQ-039 SHALL verify: evt_ready held 0 for 20 cycles with 3 bytes queued -> evt_valid/outputs stable, no pops until acceptance, remaining bytes then drained in order.
REQ-040 SHALL verify: E0 pending then kbd_overflow=1 -> err_ovf=1, next byte 0x74 emits ext=0; 256 distinct make events -> press_cnt wraps to 0x00.
REQ-041 SHALL verify: clrn pulsed low during POP -> kbd_nextdata_n=1 immediately, all outputs at reset values, no event for the interrupted byte.

Source files
------------

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard scan-code controller: pops bytes from the receiver FIFO, strips
// E0/F0 prefixes, filters typematic repeats and presents key events with a valid/ready handshake.
module ps2_kbd_ctrl #(
   parameter int unsigned CNT_W         = 8,
   parameter bit          FILTER_REPEAT = 1'b1
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic [7:0]       kbd_data,
   input  logic             kbd_ready,
   input  logic             kbd_overflow,
   output logic             kbd_nextdata_n,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [7:0]       evt_code,
   output logic             evt_ext,
   output logic             evt_break,
   output logic             key_held,
   output logic [CNT_W-1:0] press_cnt,
   output logic             err_ovf
);

   typedef enum logic [1:0] {StIdle, StPop, StCapt, StEmit} state_e;

   state_e           state_q, state_d;
   logic             ext_pend_q, ext_pend_d;
   logic             brk_pend_q, brk_pend_d;
   logic [7:0]       code_q, code_d;
   logic             ext_q, ext_d;
   logic             brk_q, brk_d;
   logic [8:0]       held_q, held_d;
   logic             key_held_q, key_held_d;
   logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
   logic             err_ovf_q, err_ovf_d;

   logic is_ctrl;
   logic is_repeat;

   always_comb begin
      is_ctrl = 1'b0;
      unique case (kbd_data)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_ctrl = 1'b1;
         default: is_ctrl = 1'b0;
      endcase
   end

   assign is_repeat = FILTER_REPEAT && key_held_q && (held_q == {ext_pend_q, kbd_data});

   always_comb begin
      state_d     = state_q;
      ext_pend_d  = ext_pend_q;
      brk_pend_d  = brk_pend_q;
      code_d      = code_q;
      ext_d       = ext_q;
      brk_d       = brk_q;
      held_d      = held_q;
      key_held_d  = key_held_q;
      press_cnt_d = press_cnt_q;
      err_ovf_d   = err_ovf_q;

      unique case (state_q)
         StIdle: begin
            if (kbd_ready) state_d = StPop;
         end
         StPop: begin
            state_d = StCapt;
         end
         StCapt: begin
            state_d = StIdle;
            if (kbd_data == 8'hE0) begin
               ext_pend_d = 1'b1;
            end else if (kbd_data == 8'hF0) begin
               brk_pend_d = 1'b1;
            end else if (is_ctrl) begin
               ext_pend_d = 1'b0;
               brk_pend_d = 1'b0;
            end else begin
               ext_pend_d = 1'b0;
               brk_pend_d = 1'b0;
               code_d     = kbd_data;
               ext_d      = ext_pend_q;
               brk_d      = brk_pend_q;
               if (brk_pend_q) begin
                  if (held_q == {ext_pend_q, kbd_data}) key_held_d = 1'b0;
                  state_d = StEmit;
               end else if (!is_repeat) begin
                  held_d      = {ext_pend_q, kbd_data};
                  key_held_d  = 1'b1;
                  press_cnt_d = press_cnt_q + CNT_W'(1);
                  state_d     = StEmit;
               end
            end
         end
         StEmit: begin
            if (evt_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // First overflow wins over any prefix captured this cycle: partial sequences are suspect.
      if (kbd_overflow && !err_ovf_q) begin
         err_ovf_d  = 1'b1;
         ext_pend_d = 1'b0;
         brk_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q     <= StIdle;
         ext_pend_q  <= 1'b0;
         brk_pend_q  <= 1'b0;
         code_q      <= 8'h00;
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         held_q      <= 9'h000;
         key_held_q  <= 1'b0;
         press_cnt_q <= '0;
         err_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ext_pend_q  <= ext_pend_d;
         brk_pend_q  <= brk_pend_d;
         code_q      <= code_d;
         ext_q       <= ext_d;
         brk_q       <= brk_d;
         held_q      <= held_d;
         key_held_q  <= key_held_d;
         press_cnt_q <= press_cnt_d;
         err_ovf_q   <= err_ovf_d;
      end
   end

   assign kbd_nextdata_n = (state_q != StPop);
   assign evt_valid      = (state_q == StEmit);
   assign evt_code       = code_q;
   assign evt_ext        = ext_q;
   assign evt_break      = brk_q;
   assign key_held       = key_held_q;
   assign press_cnt      = press_cnt_q;
   assign err_ovf        = err_ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: a shared FIFO model feeds a repeat-filtering DUT and a
// non-filtering DUT; expected events are queued on stimulus and checked at each handshake.
module tb_ps2_kbd_ctrl;

   logic       clk = 1'b0;
   logic       clrn;
   logic [7:0] kbd_data = 8'h00;
   logic [7:0] kbd_data0 = 8'h00;
   logic       kbd_ready, kbd_ready0;
   logic       kbd_overflow;
   logic       kbd_nextdata_n, kbd_nextdata_n0;
   logic       evt_valid, evt_valid0;
   logic       evt_ready;
   logic [7:0] evt_code, evt_code0;
   logic       evt_ext, evt_ext0;
   logic       evt_break, evt_break0;
   logic       key_held, key_held0;
   logic [7:0] press_cnt, press_cnt0;
   logic       err_ovf, err_ovf0;

   ps2_kbd_ctrl #(.CNT_W(8), .FILTER_REPEAT(1'b1)) dut (
      .clk(clk), .clrn(clrn), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
      .kbd_overflow(kbd_overflow), .kbd_nextdata_n(kbd_nextdata_n), .evt_valid(evt_valid),
      .evt_ready(evt_ready), .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break),
      .key_held(key_held), .press_cnt(press_cnt), .err_ovf(err_ovf)
   );

   ps2_kbd_ctrl #(.CNT_W(8), .FILTER_REPEAT(1'b0)) dut0 (
      .clk(clk), .clrn(clrn), .kbd_data(kbd_data0), .kbd_ready(kbd_ready0),
      .kbd_overflow(kbd_overflow), .kbd_nextdata_n(kbd_nextdata_n0), .evt_valid(evt_valid0),
      .evt_ready(1'b1), .evt_code(evt_code0), .evt_ext(evt_ext0), .evt_break(evt_break0),
      .key_held(key_held0), .press_cnt(press_cnt0), .err_ovf(err_ovf0)
   );

   always #5 clk = ~clk;

   // Receiver FIFO model: both DUTs read the same byte stream through their own read pointers.
   logic [7:0] mem [0:1023];
   logic [9:0] wr_ptr = '0;
   logic [9:0] rd_ptr = '0;
   logic [9:0] rd_ptr0 = '0;
   int         pop_cnt = 0;
   int         evt_cnt = 0;
   int         evt_cnt0 = 0;

   assign kbd_ready  = (rd_ptr != wr_ptr);
   assign kbd_ready0 = (rd_ptr0 != wr_ptr);

   always @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         rd_ptr  <= wr_ptr;
         rd_ptr0 <= wr_ptr;
      end else begin
         if (!kbd_nextdata_n) begin
            kbd_data <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + 10'd1;
            pop_cnt  <= pop_cnt + 1;
         end
         if (!kbd_nextdata_n0) begin
            kbd_data0 <= mem[rd_ptr0];
            rd_ptr0   <= rd_ptr0 + 10'd1;
         end
         if (evt_valid && evt_ready) evt_cnt <= evt_cnt + 1;
         if (evt_valid0) evt_cnt0 <= evt_cnt0 + 1;
      end
   end

   int         total = 0;
   int         bad = 0;
   logic [9:0] exp_q [$];
   logic [7:0] exp_press = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr = wr_ptr + 10'd1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for a handshake on the filtering DUT and compare against the scoreboard head.
   task automatic expect_evt(input string tag);
      logic [9:0] e;
      bit         got;
      got = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (evt_valid && evt_ready) begin
            got = 1'b1;
            break;
         end
      end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3FF;
      if (got) chk(tag, {evt_ext, evt_break, evt_code}, e);
      else chk({tag, "_timeout"}, got, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int  p, ev, pc0, ev0;
      bit  seen, stable;

      clrn         = 1'b0;
      evt_ready    = 1'b1;
      kbd_overflow = 1'b0;
      #1;
      chk("rst_nextdata_n", kbd_nextdata_n, 1);
      chk("rst_evt_valid", evt_valid, 0);
      chk("rst_outputs", {evt_code, evt_ext, evt_break, key_held, err_ovf}, 0);
      chk("rst_press_cnt", press_cnt, 0);
      idle(2);
      clrn = 1'b1;
      idle(2);

      // Single make: latency n+1 pop, n+3 valid, one pop total.
      p = pop_cnt;
      push(8'h1C);
      exp_q.push_back({2'b00, 8'h1C});
      exp_press++;
      idle(1);
      chk("lat_pop_n1", kbd_nextdata_n, 0);
      idle(1);
      chk("lat_capt_n2", {kbd_nextdata_n, evt_valid}, 2'b10);
      idle(1);
      chk("lat_valid_n3", evt_valid, 1);
      expect_evt("make_1c");
      idle(3);
      chk("make_pops", pop_cnt - p, 1);
      chk("make_press", press_cnt, exp_press);
      chk("make_held", key_held, 1);

      push(8'hF0);
      push(8'h1C);
      exp_q.push_back({2'b01, 8'h1C});
      expect_evt("break_1c");
      chk("break_held", key_held, 0);

      // Extended break: two prefixes dropped, one event, three pops.
      idle(3);
      p  = pop_cnt;
      ev = evt_cnt;
      push(8'hE0);
      push(8'hF0);
      push(8'h75);
      exp_q.push_back({2'b11, 8'h75});
      expect_evt("ext_break_75");
      idle(5);
      chk("ext_break_pops", pop_cnt - p, 3);
      chk("ext_break_evts", evt_cnt - ev, 1);

      // Typematic repeat: filtered on dut, passed on dut0.
      idle(10);
      ev  = evt_cnt;
      ev0 = evt_cnt0;
      pc0 = int'(press_cnt0);
      push(8'h1C);
      push(8'h1C);
      push(8'h1C);
      exp_q.push_back({2'b00, 8'h1C});
      exp_press++;
      expect_evt("repeat_first");
      idle(15);
      chk("repeat_evts", evt_cnt - ev, 1);
      chk("repeat_press", press_cnt, exp_press);
      chk("nofilt_evts", evt_cnt0 - ev0, 3);
      chk("nofilt_press", 8'(int'(press_cnt0) - pc0), 3);

      // Backpressure: outputs frozen and no pops while evt_ready=0.
      evt_ready = 1'b0;
      push(8'h15);
      push(8'h1D);
      push(8'h24);
      exp_q.push_back({2'b00, 8'h15});
      exp_q.push_back({2'b00, 8'h1D});
      exp_q.push_back({2'b00, 8'h24});
      exp_press += 8'd3;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         idle(1);
         if (evt_valid) begin
            seen = 1'b1;
            break;
         end
      end
      chk("bp_valid_seen", seen, 1);
      p      = pop_cnt;
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         idle(1);
         if (!evt_valid || evt_code !== 8'h15 || evt_ext !== 1'b0 || evt_break !== 1'b0 ||
             pop_cnt != p || kbd_nextdata_n !== 1'b1) stable = 1'b0;
      end
      chk("bp_stable", stable, 1);
      evt_ready = 1'b1;
      expect_evt("bp_ev0");
      expect_evt("bp_ev1");
      expect_evt("bp_ev2");
      chk("bp_press", press_cnt, exp_press);

      // Overflow after a pending E0 clears the prefix.
      idle(3);
      push(8'hE0);
      idle(8);
      kbd_overflow = 1'b1;
      idle(1);
      chk("ovf_flag", err_ovf, 1);
      push(8'h74);
      exp_q.push_back({2'b00, 8'h74});
      exp_press++;
      expect_evt("ovf_74");
      idle(2);
      chk("ovf_sticky", err_ovf, 1);

      // Reset mid-POP.
      kbd_overflow = 1'b0;
      idle(3);
      push(8'h2B);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (!kbd_nextdata_n) begin
            seen = 1'b1;
            break;
         end
         idle(1);
      end
      chk("rstpop_in_pop", seen, 1);
      ev   = evt_cnt;
      clrn = 1'b0;
      #1;
      chk("rstpop_nextdata_n", kbd_nextdata_n, 1);
      chk("rstpop_evt_valid", evt_valid, 0);
      chk("rstpop_outputs", {evt_code, evt_ext, evt_break, key_held, err_ovf}, 0);
      chk("rstpop_press", press_cnt, 0);
      idle(1);
      clrn = 1'b1;
      exp_press = 8'h00;
      idle(1);
      chk("rstpop_no_pop", kbd_nextdata_n, 1);
      idle(10);
      chk("rstpop_no_evt", evt_cnt - ev, 0);

      // 256 alternating makes wrap the counter.
      for (int i = 0; i < 256; i++) begin
         push((i % 2 == 0) ? 8'h16 : 8'h1E);
         exp_q.push_back({2'b00, ((i % 2 == 0) ? 8'h16 : 8'h1E)});
      end
      for (int i = 0; i < 256; i++) begin
         expect_evt("wrap_evt");
         exp_press++;
         if (i == 254) chk("wrap_255", press_cnt, exp_press);
      end
      chk("wrap_zero", press_cnt, exp_press);
      chk("sb_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
